// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the Mini SRC control unit: opcodes, ALU codes, bus selects, states.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_MUL = 5'b00101;
  localparam logic [4:0] OP_DIV = 5'b00110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0110;

  localparam logic [4:0] SEL_ZHI = 5'd18;
  localparam logic [4:0] SEL_ZLO = 5'd19;
  localparam logic [4:0] SEL_PC  = 5'd20;
  localparam logic [4:0] SEL_MDR = 5'd21;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_T0      = 4'd1;
  localparam state_t S_T1      = 4'd2;
  localparam state_t S_T2      = 4'd3;
  localparam state_t S_T3      = 4'd4;
  localparam state_t S_T4      = 4'd5;
  localparam state_t S_T5      = 4'd6;
  localparam state_t S_T6      = 4'd7;
  localparam state_t S_ILLEGAL = 4'd8;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;

  logic        mem_ready;
  logic [31:0] IR;
  logic        e_PC;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_HI;
  logic        e_LO;
  logic        e_MDR;
  logic        e_MAR;
  logic        e_GP;
  logic        incPC;
  logic        MDR_read;
  logic [3:0]  GP_addr;
  logic [4:0]  BusDataSelect;
  logic [3:0]  ALU_op;

  modport master (
    input  mem_ready, IR,
    output e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
    output incPC, MDR_read, GP_addr, BusDataSelect, ALU_op
  );

  modport slave (
    output mem_ready, IR,
    input  e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
    input  incPC, MDR_read, GP_addr, BusDataSelect, ALU_op
  );

endinterface

// File: rtl/control_decode.sv
// Combinational IR decode: instruction class, ALU function and register fields.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_t   op_class,
  output logic [3:0]  alu_op,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc
);

  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  // Map opcode to class and ALU function; unknown opcodes are illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALU_ADD;
    case (ir[31:27])
      OP_ADD: begin op_class = CLS_ALU;    alu_op = ALU_ADD; end
      OP_SUB: begin op_class = CLS_ALU;    alu_op = ALU_SUB; end
      OP_AND: begin op_class = CLS_ALU;    alu_op = ALU_AND; end
      OP_OR:  begin op_class = CLS_ALU;    alu_op = ALU_OR;  end
      OP_MUL: begin op_class = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_DIV: begin op_class = CLS_MULDIV; alu_op = ALU_DIV; end
      default: begin op_class = CLS_ILLEGAL; alu_op = ALU_ADD; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC sequencer: fetch T0-T2, execute T3-T6, Moore control decode.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  control_sequencer_if.master ctrl,
  output logic                busy,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count
);

  state_t    state;
  state_t    state_nxt;
  op_class_t op_class;
  logic [3:0] alu_op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;

  control_decode u_decode (
    .ir       (ctrl.IR),
    .op_class (op_class),
    .alu_op   (alu_op),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc)
  );

  // Next-state: T1 waits for memory, execute length depends on instruction class.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_T0;
      S_T0:      state_nxt = S_T1;
      S_T1:      if (ctrl.mem_ready) state_nxt = S_T2;
      S_T2:      state_nxt = S_T3;
      S_T3:      state_nxt = (op_class == CLS_ILLEGAL) ? S_ILLEGAL : S_T4;
      S_T4:      state_nxt = S_T5;
      S_T5: begin
        if (op_class == CLS_MULDIV) state_nxt = S_T6;
        else                        state_nxt = run ? S_T0 : S_IDLE;
      end
      S_T6:      state_nxt = run ? S_T0 : S_IDLE;
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register, retire counter and sticky illegal flag.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      instr_count <= '0;
      illegal_op  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (instr_done) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state == S_T3 && op_class == CLS_ILLEGAL) illegal_op <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE) && (state != S_ILLEGAL);

  // Moore output decode from state and IR fields; everything defaults to 0.
  always_comb begin
    ctrl.e_PC          = 1'b0;
    ctrl.e_IR          = 1'b0;
    ctrl.e_Y           = 1'b0;
    ctrl.e_Z           = 1'b0;
    ctrl.e_HI          = 1'b0;
    ctrl.e_LO          = 1'b0;
    ctrl.e_MDR         = 1'b0;
    ctrl.e_MAR         = 1'b0;
    ctrl.e_GP          = 1'b0;
    ctrl.incPC         = 1'b0;
    ctrl.MDR_read      = 1'b0;
    ctrl.GP_addr       = 4'd0;
    ctrl.BusDataSelect = 5'd0;
    ctrl.ALU_op        = 4'd0;
    instr_done         = 1'b0;
    case (state)
      S_T0: begin
        ctrl.BusDataSelect = SEL_PC;
        ctrl.e_MAR         = 1'b1;
        ctrl.incPC         = 1'b1;
        ctrl.e_Z           = 1'b1;
      end
      S_T1: begin
        ctrl.BusDataSelect = SEL_ZLO;
        ctrl.e_PC          = 1'b1;
        ctrl.MDR_read      = 1'b1;
        ctrl.e_MDR         = 1'b1;
      end
      S_T2: begin
        ctrl.BusDataSelect = SEL_MDR;
        ctrl.e_IR          = 1'b1;
      end
      S_T3: begin
        if (op_class == CLS_ALU) begin
          ctrl.BusDataSelect = {1'b0, rb};
          ctrl.e_Y           = 1'b1;
        end else if (op_class == CLS_MULDIV) begin
          ctrl.BusDataSelect = {1'b0, ra};
          ctrl.e_Y           = 1'b1;
        end
      end
      S_T4: begin
        ctrl.ALU_op = alu_op;
        ctrl.e_Z    = 1'b1;
        ctrl.BusDataSelect = (op_class == CLS_MULDIV) ? {1'b0, rb} : {1'b0, rc};
      end
      S_T5: begin
        ctrl.BusDataSelect = SEL_ZLO;
        if (op_class == CLS_MULDIV) begin
          ctrl.e_LO = 1'b1;
        end else begin
          ctrl.e_GP    = 1'b1;
          ctrl.GP_addr = ra;
          instr_done   = 1'b1;
        end
      end
      S_T6: begin
        ctrl.BusDataSelect = SEL_ZHI;
        ctrl.e_HI          = 1'b1;
        instr_done         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: small behavioural datapath around the sequencer, per-cycle control checks.
module tb_control_sequencer;

  logic       clock = 1'b0;
  logic       clear;
  logic       run;
  logic       busy;
  logic       instr_done;
  logic       illegal_op;
  logic [1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  control_sequencer_if bus_if ();

  control_sequencer #(.CNT_W(2)) dut (
    .clock       (clock),
    .clear       (clear),
    .run         (run),
    .ctrl        (bus_if),
    .busy        (busy),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  // Enable vector order: e_PC e_IR e_Y e_Z e_HI e_LO e_MDR e_MAR e_GP incPC MDR_read
  localparam logic [10:0] EN_T0 = 11'b00010001010;
  localparam logic [10:0] EN_T1 = 11'b10000010001;
  localparam logic [10:0] EN_T2 = 11'b01000000000;
  localparam logic [10:0] EN_Y  = 11'b00100000000;
  localparam logic [10:0] EN_Z  = 11'b00010000000;
  localparam logic [10:0] EN_GP = 11'b00000000100;
  localparam logic [10:0] EN_LO = 11'b00000100000;
  localparam logic [10:0] EN_HI = 11'b00001000000;

  localparam logic [31:0] IR_MUL = 32'h2A360000;
  localparam logic [31:0] IR_ADD = 32'h01188000;
  localparam logic [31:0] IR_ILL = 32'hF8000000;
  localparam logic [31:0] IR_DIV = 32'h34480000;

  // Behavioural datapath model
  logic [31:0] rf [16];
  logic [31:0] y, pc, mdr, hi, lo, mdatain, bus;
  logic [63:0] z;

  always_comb begin
    bus = 32'd0;
    if (bus_if.BusDataSelect < 5'd16) bus = rf[bus_if.BusDataSelect[3:0]];
    else if (bus_if.BusDataSelect == 5'd18) bus = z[63:32];
    else if (bus_if.BusDataSelect == 5'd19) bus = z[31:0];
    else if (bus_if.BusDataSelect == 5'd20) bus = pc;
    else if (bus_if.BusDataSelect == 5'd21) bus = mdr;
  end

  always @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd7;  rf[3] <= 32'd5;  rf[4] <= 32'd6;
      rf[6] <= 32'd4;  rf[8] <= 32'd17; rf[9] <= 32'd5;
      y <= 0; z <= 0; pc <= 0; mdr <= 0; hi <= 0; lo <= 0;
      bus_if.IR <= 32'd0;
    end else begin
      if (bus_if.e_Y) y <= bus;
      if (bus_if.e_Z) begin
        if (bus_if.incPC) z <= {32'd0, bus + 32'd1};
        else case (bus_if.ALU_op)
          4'b0000: z <= {32'd0, y + bus};
          4'b0001: z <= {32'd0, y - bus};
          4'b0010: z <= {32'd0, y & bus};
          4'b0011: z <= {32'd0, y | bus};
          4'b0101: z <= {32'd0, y} * {32'd0, bus};
          4'b0110: z <= {y % bus, y / bus};
          default: z <= 64'd0;
        endcase
      end
      if (bus_if.e_PC)  pc  <= bus;
      if (bus_if.e_MDR) mdr <= bus_if.MDR_read ? mdatain : bus;
      if (bus_if.e_IR)  bus_if.IR <= bus;
      if (bus_if.e_LO)  lo  <= bus;
      if (bus_if.e_HI)  hi  <= bus;
      if (bus_if.e_GP)  rf[bus_if.GP_addr] <= bus;
    end
  end

  function automatic logic [31:0] got_ctl();
    return {5'd0, bus_if.e_PC, bus_if.e_IR, bus_if.e_Y, bus_if.e_Z, bus_if.e_HI, bus_if.e_LO,
            bus_if.e_MDR, bus_if.e_MAR, bus_if.e_GP, bus_if.incPC, bus_if.MDR_read,
            bus_if.BusDataSelect, bus_if.GP_addr, bus_if.ALU_op, busy, instr_done, illegal_op};
  endfunction

  function automatic logic [31:0] ex(input logic [10:0] en, input logic [4:0] sel,
                                     input logic [3:0] gp, input logic [3:0] op,
                                     input logic b, input logic d, input logic il);
    return {5'd0, en, sel, gp, op, b, d, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [31:0] exp);
    @(negedge clock);
    chk(tag, got_ctl(), exp);
  endtask

  initial begin
    clear = 1'b1;
    run = 1'b0;
    bus_if.mem_ready = 1'b1;
    mdatain = 32'd0;
    repeat (2) @(negedge clock);
    chk("reset_ctl", got_ctl(), 32'd0);
    chk("reset_cnt", 32'(instr_count), 32'd0);

    // MUL, run dropped in T0: completes then idles
    mdatain = IR_MUL;
    clear = 1'b0;
    run = 1'b1;
    cyc("mul_t0", ex(EN_T0, 5'd20, 4'd0, 4'd0, 1, 0, 0));
    run = 1'b0;
    cyc("mul_t1", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("mul_t2", ex(EN_T2, 5'd21, 4'd0, 4'd0, 1, 0, 0));
    cyc("mul_t3", ex(EN_Y,  5'd4,  4'd0, 4'd0, 1, 0, 0));
    cyc("mul_t4", ex(EN_Z,  5'd6,  4'd0, 4'b0101, 1, 0, 0));
    cyc("mul_t5", ex(EN_LO, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("mul_t6", ex(EN_HI, 5'd18, 4'd0, 4'd0, 1, 1, 0));
    cyc("mul_idle", 32'd0);
    chk("mul_cnt", 32'(instr_count), 32'd1);
    chk("mul_lo", lo, 32'd24);
    chk("mul_hi", hi, 32'd0);
    chk("mul_ir", bus_if.IR, IR_MUL);
    chk("mul_pc", pc, 32'd1);
    cyc("mul_stay_idle", 32'd0);

    // ADD with three T1 stall cycles, then back-to-back illegal opcode
    mdatain = IR_ADD;
    run = 1'b1;
    cyc("add_t0", ex(EN_T0, 5'd20, 4'd0, 4'd0, 1, 0, 0));
    bus_if.mem_ready = 1'b0;
    cyc("add_t1_a", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("add_t1_b", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("add_t1_c", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("add_t1_d", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    bus_if.mem_ready = 1'b1;
    cyc("add_t2", ex(EN_T2, 5'd21, 4'd0, 4'd0, 1, 0, 0));
    cyc("add_t3", ex(EN_Y,  5'd3,  4'd0, 4'd0, 1, 0, 0));
    cyc("add_t4", ex(EN_Z,  5'd1,  4'd0, 4'b0000, 1, 0, 0));
    cyc("add_t5", ex(EN_GP, 5'd19, 4'd2, 4'd0, 1, 1, 0));
    mdatain = IR_ILL;
    cyc("b2b_t0", ex(EN_T0, 5'd20, 4'd0, 4'd0, 1, 0, 0));
    chk("add_r2", rf[2], 32'd12);
    chk("add_pc", pc, 32'd2);
    chk("add_cnt", 32'(instr_count), 32'd2);
    cyc("ill_t1", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("ill_t2", ex(EN_T2, 5'd21, 4'd0, 4'd0, 1, 0, 0));
    cyc("ill_t3", ex(11'd0, 5'd0, 4'd0, 4'd0, 1, 0, 0));
    for (int i = 0; i < 4; i++) cyc("ill_hold", ex(11'd0, 5'd0, 4'd0, 4'd0, 0, 0, 1));
    chk("ill_cnt", 32'(instr_count), 32'd2);

    // Asynchronous clear out of ILLEGAL
    #1 clear = 1'b1;
    #1 chk("clr_ill_ctl", got_ctl(), 32'd0);
    chk("clr_ill_cnt", 32'(instr_count), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    mdatain = IR_DIV;

    // DIV with run dropped during T4
    cyc("div_t0", ex(EN_T0, 5'd20, 4'd0, 4'd0, 1, 0, 0));
    cyc("div_t1", ex(EN_T1, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("div_t2", ex(EN_T2, 5'd21, 4'd0, 4'd0, 1, 0, 0));
    cyc("div_t3", ex(EN_Y,  5'd8,  4'd0, 4'd0, 1, 0, 0));
    cyc("div_t4", ex(EN_Z,  5'd9,  4'd0, 4'b0110, 1, 0, 0));
    run = 1'b0;
    cyc("div_t5", ex(EN_LO, 5'd19, 4'd0, 4'd0, 1, 0, 0));
    cyc("div_t6", ex(EN_HI, 5'd18, 4'd0, 4'd0, 1, 1, 0));
    cyc("div_idle", 32'd0);
    chk("div_lo", lo, 32'd3);
    chk("div_hi", hi, 32'd2);
    chk("div_cnt", 32'(instr_count), 32'd1);

    // MUL interrupted by clear in T4
    mdatain = IR_MUL;
    run = 1'b1;
    repeat (4) @(negedge clock);
    cyc("mul2_t4", ex(EN_Z, 5'd6, 4'd0, 4'b0101, 1, 0, 0));
    #1 clear = 1'b1;
    run = 1'b0;
    #1 chk("clr_t4_ctl", got_ctl(), 32'd0);
    chk("clr_t4_cnt", 32'(instr_count), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    cyc("clr_t4_idle", 32'd0);

    // Four back-to-back ADDs: 2-bit counter wraps 3 -> 0
    mdatain = IR_ADD;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clock);
      cyc("wrap_t5", ex(EN_GP, 5'd19, 4'd2, 4'd0, 1, 1, 0));
      chk("wrap_cnt", 32'(instr_count), 32'(i));
      if (i == 3) run = 1'b0;
    end
    cyc("wrap_idle", 32'd0);
    chk("wrap_cnt_zero", 32'(instr_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
